// File: rtl/ikaopm_timer_ctrl.sv
`default_nettype none
//============================================================================
//  Module   : ikaopm_timer_ctrl
//  Purpose  : Timer register-side controller. Decodes CPU address/data
//             writes into timer control registers, generates one-tick
//             flag-reset strobes and the write-busy window, and schedules
//             the CSM key-on frame on timer A overflow.
//  Options  : IKAOPM_CSM_EN  - when defined, the CSM frame scheduler is
//             built; otherwise o_CSM_KON / o_CSM_SLOT are tied to zero and
//             0x14 D7 is not stored.
//  Revision : 1.0  initial release
//============================================================================
module ikaopm_timer_ctrl #(
    parameter int BUSY_LEN  = 64,
    parameter int CSM_FRAME = 32
) (
    input  logic       i_EMUCLK,
    input  logic       i_MRST_n,
    input  logic       i_phi1_NCEN_n,
    input  logic       i_CYCLE_31,
    input  logic       i_WR,
    input  logic       i_A0,
    input  logic [7:0] i_D,
    input  logic       i_TIMERA_OVFL,
    output logic [7:0] o_CLKA1,
    output logic [1:0] o_CLKA2,
    output logic [7:0] o_CLKB,
    output logic       o_TIMERA_RUN,
    output logic       o_TIMERB_RUN,
    output logic       o_TIMERA_IRQ_EN,
    output logic       o_TIMERB_IRQ_EN,
    output logic       o_TIMERA_FRST,
    output logic       o_TIMERB_FRST,
    output logic       o_TEST_D2,
    output logic       o_BUSY,
    output logic       o_CSM_KON,
    output logic [4:0] o_CSM_SLOT
);

    localparam logic [7:0] c_BUSY_LOAD  = 8'(BUSY_LEN);
    localparam logic [7:0] c_ADDR_TEST  = 8'h01;
    localparam logic [7:0] c_ADDR_CLKA1 = 8'h10;
    localparam logic [7:0] c_ADDR_CLKA2 = 8'h11;
    localparam logic [7:0] c_ADDR_CLKB  = 8'h12;
    localparam logic [7:0] c_ADDR_CTRL  = 8'h14;

    // A tick is a phi1 negative-edge enable; nothing moves between ticks.
    logic w_tick;
    logic w_addr_wr;
    logic w_data_wr;
    assign w_tick    = ~i_phi1_NCEN_n;
    assign w_addr_wr = w_tick & i_WR & ~i_A0;
    assign w_data_wr = w_tick & i_WR &  i_A0;

    logic [7:0] addr_q;
    logic [7:0] clka1_q;
    logic [1:0] clka2_q;
    logic [7:0] clkb_q;
    logic       runa_q;
    logic       runb_q;
    logic       irqa_q;
    logic       irqb_q;
    logic       frsta_q;
    logic       frstb_q;
    logic       test_d2_q;
`ifdef IKAOPM_CSM_EN
    logic       csm_en_q;
`endif

    // Address latch and register file; FRST strobes self-clear after one tick.
    always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            addr_q    <= 8'h00;
            clka1_q   <= 8'h00;
            clka2_q   <= 2'b00;
            clkb_q    <= 8'h00;
            runa_q    <= 1'b0;
            runb_q    <= 1'b0;
            irqa_q    <= 1'b0;
            irqb_q    <= 1'b0;
            frsta_q   <= 1'b0;
            frstb_q   <= 1'b0;
            test_d2_q <= 1'b0;
`ifdef IKAOPM_CSM_EN
            csm_en_q  <= 1'b0;
`endif
        end else if (w_tick) begin
            frsta_q <= 1'b0;
            frstb_q <= 1'b0;
            if (w_addr_wr) begin
                addr_q <= i_D;
            end
            if (w_data_wr) begin
                case (addr_q)
                    c_ADDR_TEST:  test_d2_q <= i_D[2];
                    c_ADDR_CLKA1: clka1_q   <= i_D;
                    c_ADDR_CLKA2: clka2_q   <= i_D[1:0];
                    c_ADDR_CLKB:  clkb_q    <= i_D;
                    c_ADDR_CTRL: begin
`ifdef IKAOPM_CSM_EN
                        csm_en_q <= i_D[7];
`endif
                        frstb_q  <= i_D[5];
                        frsta_q  <= i_D[4];
                        irqb_q   <= i_D[3];
                        irqa_q   <= i_D[2];
                        runb_q   <= i_D[1];
                        runa_q   <= i_D[0];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Busy window: every data write (re)loads the counter, which drains by one per tick.
    logic [7:0] busy_cnt_q;
    logic [7:0] busy_cnt_d;

    always_comb begin
        busy_cnt_d = busy_cnt_q;
        if (w_data_wr) begin
            busy_cnt_d = c_BUSY_LOAD;
        end else if (busy_cnt_q != 8'h00) begin
            busy_cnt_d = busy_cnt_q - 8'h01;
        end
    end

    // Busy counter register.
    always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            busy_cnt_q <= 8'h00;
        end else if (w_tick) begin
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign o_CLKA1         = clka1_q;
    assign o_CLKA2         = clka2_q;
    assign o_CLKB          = clkb_q;
    assign o_TIMERA_RUN    = runa_q;
    assign o_TIMERB_RUN    = runb_q;
    assign o_TIMERA_IRQ_EN = irqa_q;
    assign o_TIMERB_IRQ_EN = irqb_q;
    assign o_TIMERA_FRST   = frsta_q;
    assign o_TIMERB_FRST   = frstb_q;
    assign o_TEST_D2       = test_d2_q;
    assign o_BUSY          = (busy_cnt_q != 8'h00);

`ifdef IKAOPM_CSM_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2
    } csm_state_t;

    localparam logic [4:0] c_LAST_SLOT = 5'(CSM_FRAME - 1);

    csm_state_t state_q;
    logic       pend_q;
    logic       kon_q;
    logic [4:0] slot_q;

    // Overflow qualified by the enable as it stood before this tick's write.
    logic w_ovfl;
    assign w_ovfl = i_TIMERA_OVFL & csm_en_q;

    // CSM frame scheduler: frames start on the slot after CYCLE_31 and may chain back-to-back.
    always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            state_q <= ST_IDLE;
            pend_q  <= 1'b0;
            kon_q   <= 1'b0;
            slot_q  <= 5'd0;
        end else if (w_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (w_ovfl && i_CYCLE_31) begin
                        state_q <= ST_ACTIVE;
                        kon_q   <= 1'b1;
                        slot_q  <= 5'd0;
                    end else if (w_ovfl) begin
                        state_q <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (!csm_en_q) begin
                        state_q <= ST_IDLE;
                    end else if (i_CYCLE_31) begin
                        state_q <= ST_ACTIVE;
                        kon_q   <= 1'b1;
                        slot_q  <= 5'd0;
                    end
                end
                ST_ACTIVE: begin
                    if (slot_q == c_LAST_SLOT) begin
                        pend_q <= 1'b0;
                        slot_q <= 5'd0;
                        if ((pend_q | w_ovfl) & csm_en_q) begin
                            kon_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            kon_q   <= 1'b0;
                        end
                    end else begin
                        slot_q <= slot_q + 5'd1;
                        pend_q <= (pend_q | w_ovfl) & csm_en_q;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    pend_q  <= 1'b0;
                    kon_q   <= 1'b0;
                    slot_q  <= 5'd0;
                end
            endcase
        end
    end

    assign o_CSM_KON  = kon_q;
    assign o_CSM_SLOT = slot_q;
`else
    // Scheduler absent: CSM inputs are intentionally left without a load.
    logic w_unused_csm;
    assign w_unused_csm = &{1'b0, i_TIMERA_OVFL, i_CYCLE_31, (CSM_FRAME == 32)};

    assign o_CSM_KON  = 1'b0;
    assign o_CSM_SLOT = 5'd0;
`endif

endmodule
`default_nettype wire

// File: doc/ikaopm_timer_ctrl.md
Name: ikaopm_timer_ctrl

Overview:
Register-side controller for the timer block: decodes CPU address/data writes into the timer control registers.
- Generates one-tick flag-reset strobes and the write-busy window.
- Schedules the CSM (composite sine mode) key-on frame triggered by timer A overflow/load.
- Sits between the bus interface (synchronized write strobes) and the timer/envelope blocks.
- All state advances on the phi1 negative-edge enable.

Parameters:
BUSY_LEN, 64, busy window length in phi1 ticks after a data write (legal range 2..255).
CSM_FRAME, 32, CSM key-on frame length in ticks (fixed 32, equal to one slot cycle).

Ports:
i_EMUCLK  in  1  emulator master clock
i_MRST_n  in  1  asynchronous active-low reset
i_phi1_NCEN_n  in  1  phi1 negative-edge clock enable (active low); all updates only when low
i_CYCLE_31  in  1  last slot of the 32-slot cycle
i_WR  in  1  synchronized write strobe, one tick wide
i_A0  in  1  0 = address write, 1 = data write
i_D  in  8  write data
i_TIMERA_OVFL  in  1  timer A load/overflow pulse from timer block
o_CLKA1  out  8  timer A period high bits (reg 0x10)
o_CLKA2  out  2  timer A period low bits (reg 0x11 D1:0)
o_CLKB  out  8  timer B period (reg 0x12)
o_TIMERA_RUN / o_TIMERB_RUN  out  1 each  reg 0x14 D0 / D1
o_TIMERA_IRQ_EN / o_TIMERB_IRQ_EN  out  1 each  reg 0x14 D2 / D3
o_TIMERA_FRST / o_TIMERB_FRST  out  1 each  one-tick flag reset strobes (0x14 D4 / D5)
o_TEST_D2  out  1  test register 0x01 D2
o_BUSY  out  1  write busy flag
o_CSM_KON  out  1  CSM key-on active
o_CSM_SLOT  out  5  slot index within the CSM frame

Behaviour:
- Reset (async, any time): all outputs 0, address latch 0x00, busy counter 0, CSM FSM IDLE, pending flag 0.
- A tick is a rising edge of i_EMUCLK with i_phi1_NCEN_n low. Non-tick edges hold all state.
- Address write (i_WR & ~i_A0): address latch <= i_D. No register change. Busy unaffected.
- Data write (i_WR & i_A0) decodes the latched address:
  - 0x01: TEST_D2 <= D2.
  - 0x10: CLKA1 <= D.
  - 0x11: CLKA2 <= D1:0.
  - 0x12: CLKB <= D.
  - 0x14: CSM_EN <= D7; IRQ_EN B/A <= D3/D2; RUN B/A <= D1/D0.
  - Any other address: no change here.
- Register outputs reflect a data write on the tick after the strobe (latency 1 tick).
- FRST strobes: a 0x14 data write with D4/D5 set pulses o_TIMERA_FRST/o_TIMERB_FRST high for exactly 1 tick. The strobes are not stored.
- Busy:
  - Any data write (any address) loads the counter with BUSY_LEN; o_BUSY = (counter != 0); counter decrements each tick.
  - A data write while busy is still accepted and reloads the counter to BUSY_LEN.
- CSM FSM, states IDLE, ARMED, ACTIVE. ovfl = i_TIMERA_OVFL & CSM_EN.
  - IDLE: if ovfl & i_CYCLE_31 -> ACTIVE; else if ovfl -> ARMED.
  - ARMED: if i_CYCLE_31 -> ACTIVE. If CSM_EN is cleared -> IDLE.
  - ACTIVE: o_CSM_KON = 1; o_CSM_SLOT starts at 0 on entry and increments each tick.
    - ovfl during ACTIVE sets pending.
    - At slot 31: if pending (and CSM_EN still 1) -> clear pending and restart ACTIVE at slot 0; else -> IDLE.
    - Clearing CSM_EN during ACTIVE does not truncate the frame, but drops pending.
  - o_CSM_SLOT = 0 outside ACTIVE.
- Simultaneous data write to 0x14 and ovfl: the ovfl qualification uses the old CSM_EN value.

Optional Feature:
IKAOPM_CSM_EN
- Defined: CSM FSM as above.
- Undefined: no FSM logic; o_CSM_KON = 0 and o_CSM_SLOT = 0 constant; D7 of 0x14 is ignored (CSM_EN is not stored).
- Register and busy behaviour are identical either way.

Test Plan:
- Reset, then write addr 0x10 and data 0xA5, then addr 0x11 and data 0x03 -> o_CLKA1 = 0xA5 and o_CLKA2 = 2'b11 one tick after each data strobe; o_BUSY high for exactly 64 ticks after the last data write.
- Write 0x14 data 0x35 -> o_TIMERA_RUN = 1, o_TIMERA_IRQ_EN = 1, o_TIMERB_RUN = 0; o_TIMERA_FRST and o_TIMERB_FRST high exactly 1 tick, then 0.
- Data write at tick 10, second data write at tick 40 -> o_BUSY stays high continuously until tick 40 + 64, then falls.
- CSM_EN = 1, single i_TIMERA_OVFL 5 ticks before i_CYCLE_31 -> o_CSM_KON high for 32 ticks starting the tick after i_CYCLE_31; o_CSM_SLOT runs 0..31, then the FSM returns to IDLE.
- CSM_EN = 1, second ovfl during ACTIVE -> frame repeats back-to-back (64 contiguous KON ticks). Same stimulus with CSM_EN cleared mid-frame -> only 32 KON ticks.
- Assert i_MRST_n low mid-ACTIVE with o_BUSY = 1 -> all outputs 0 immediately, without waiting for a clock edge.
